// File: rtl/rgb_gray_matrix3x3.sv
// RGB888 -> 8-bit luma, two-line buffer and 3x3 gray window generator.
// Three-stage pipeline (multiply, sum, window) with sync signals delayed to match.
module rgb_gray_matrix3x3 #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [23:0] per_img_data,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [7:0]  post_img_gray,
    output logic [71:0] post_matrix
);
    localparam int          AW   = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam logic [10:0] HMAX = 11'(IMG_HDISP);

    if (IMG_HDISP < 1 || IMG_HDISP > 2047 || IMG_VDISP < 1) begin : g_bad_size
        $error("rgb_gray_matrix3x3: unsupported image size");
    end

    logic        vsync_d, href_d;
    logic        accept, vs_rise, hr_fall;
    logic [10:0] cnt_x;
    logic [1:0]  cnt_y;
    logic        line_hit;

    assign accept  = per_frame_href & per_frame_clken;
    assign vs_rise = per_frame_vsync & ~vsync_d;
    assign hr_fall = href_d & ~per_frame_href;

    // Frame start takes priority over line end when both occur on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d  <= 1'b0;
            href_d   <= 1'b0;
            cnt_x    <= '0;
            cnt_y    <= '0;
            line_hit <= 1'b0;
        end else begin
            vsync_d <= per_frame_vsync;
            href_d  <= per_frame_href;
            if (vs_rise) begin
                cnt_x    <= '0;
                cnt_y    <= '0;
                line_hit <= 1'b0;
            end else if (hr_fall) begin
                cnt_x    <= '0;
                line_hit <= 1'b0;
                if (line_hit && cnt_y != 2'd2)
                    cnt_y <= cnt_y + 2'd1;
            end else if (accept) begin
                line_hit <= 1'b1;
                if (cnt_x != '1)
                    cnt_x <= cnt_x + 11'd1;
            end
        end
    end

    logic        s1_v, s2_v;
    logic [15:0] prod_r, prod_g, prod_b, sum;
    logic [10:0] s1_x, s2_x;
    logic [1:0]  s1_y, s2_y;
    logic [7:0]  gray;

    assign sum = prod_r + prod_g + prod_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s2_v   <= 1'b0;
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
            s1_x   <= '0;
            s1_y   <= '0;
            s2_x   <= '0;
            s2_y   <= '0;
            gray   <= '0;
        end else begin
            s1_v <= accept;
            s2_v <= s1_v;
            if (accept) begin
                prod_r <= 16'(per_img_data[7:0])   * 16'd77;
                prod_g <= 16'(per_img_data[15:8])  * 16'd150;
                prod_b <= 16'(per_img_data[23:16]) * 16'd29;
                s1_x   <= cnt_x;
                s1_y   <= cnt_y;
            end
            if (s1_v) begin
                gray <= sum[15:8];
                s2_x <= s1_x;
                s2_y <= s1_y;
            end
        end
    end

    logic [7:0]    lb1 [IMG_HDISP];
    logic [7:0]    lb2 [IMG_HDISP];
    logic          in_range;
    logic [AW-1:0] idx;
    logic [7:0]    tap1, tap2;

    assign in_range = (s2_x < HMAX);
    assign idx      = s2_x[AW-1:0];

    always_comb begin
        tap1 = '0;
        tap2 = '0;
        if (in_range && s2_y != 2'd0) tap1 = lb1[idx];
        if (in_range && s2_y[1])      tap2 = lb2[idx];
    end

    // Line buffers carry no reset; stale contents are hidden by the row mask.
    always_ff @(posedge clk) begin
        if (s2_v && in_range) begin
            lb1[idx] <= gray;
            lb2[idx] <= lb1[idx];
        end
    end

    logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
        end else if (s2_v) begin
            if (s2_x == '0) begin
                {p11, p12, p21, p22, p31, p32} <= '0;
            end else begin
                p11 <= p12; p12 <= p13;
                p21 <= p22; p22 <= p23;
                p31 <= p32; p32 <= p33;
            end
            p13 <= tap2;
            p23 <= tap1;
            p33 <= gray;
        end
    end

    logic [2:0] vs_sr, hr_sr, ck_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_sr <= '0;
            hr_sr <= '0;
            ck_sr <= '0;
        end else begin
            vs_sr <= {vs_sr[1:0], per_frame_vsync};
            hr_sr <= {hr_sr[1:0], per_frame_href};
            ck_sr <= {ck_sr[1:0], per_frame_clken};
        end
    end

    assign post_frame_vsync = vs_sr[2];
    assign post_frame_href  = hr_sr[2];
    assign post_frame_clken = ck_sr[2];
    assign post_img_gray    = p33;
    assign post_matrix      = {p11, p12, p13, p21, p22, p23, p31, p32, p33};

endmodule

// File: tb/tb_rgb_gray_matrix3x3.sv
// Scoreboard bench for rgb_gray_matrix3x3: expected gray/window pushed per
// accepted pixel from an image model, compared when post_frame_clken fires.
module tb_rgb_gray_matrix3x3;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [23:0] data = '0;
    logic        post_vsync, post_href, post_clken;
    logic [7:0]  post_gray;
    logic [71:0] post_matrix;

    rgb_gray_matrix3x3 #(.IMG_HDISP(W), .IMG_VDISP(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .per_frame_clken  (clken),
        .per_img_data     (data),
        .post_frame_vsync (post_vsync),
        .post_frame_href  (post_href),
        .post_frame_clken (post_clken),
        .post_img_gray    (post_gray),
        .post_matrix      (post_matrix)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  g;
        logic [71:0] m;
    } exp_t;

    exp_t sb[$];
    int   gimg [8][8];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Window from the image model: rows y-2..y, columns x-2..x, zero outside the frame.
    function automatic logic [71:0] win(input int y, input int x);
        logic [71:0] m;
        m = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                int yy, xx;
                yy = y - 2 + r;
                xx = x - 2 + c;
                if (yy >= 0 && xx >= 0)
                    m[71 - 8*(3*r + c) -: 8] = 8'(gimg[yy][xx]);
            end
        return m;
    endfunction

    task automatic push_exp(input int y, input int x, input int eg);
        exp_t e;
        gimg[y][x] = eg;
        e.g = 8'(eg);
        e.m = win(y, x);
        sb.push_back(e);
    endtask

    task automatic put_px(input int y, input int x, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b, input int eg);
        @(negedge clk);
        href  = 1'b1;
        clken = 1'b1;
        data  = {b, g, r};
        push_exp(y, x, eg);
        @(negedge clk);
        clken = 1'b0;
    endtask

    task automatic end_line();
        @(negedge clk);
        href  = 1'b0;
        clken = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_line(input int y, input int n, input int base);
        for (int x = 0; x < n; x++) begin
            int v;
            v = base + 10*y + x;
            put_px(y, x, 8'(v), 8'(v), 8'(v), v);
        end
    endtask

    task automatic send_frame(input int base);
        frame_start();
        for (int y = 0; y < 4; y++) begin
            send_line(y, W, base);
            end_line();
        end
    endtask

    // Sync outputs must equal the inputs three clocks earlier.
    logic [2:0] h1, h2, h3;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= '0; h2 <= '0; h3 <= '0;
        end else begin
            h1 <= {vsync, href, clken};
            h2 <= h1;
            h3 <= h2;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("sync_delay", {post_vsync, post_href, post_clken}, h3);
            if (post_clken) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("gray", post_gray, e.g);
                    check("window", post_matrix, e.m);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_matrix", post_matrix, 0);
        check("rst_gray", post_gray, 0);
        check("rst_sync", {post_vsync, post_href, post_clken}, 0);
        rst_n = 1'b1;

        // Gray coefficients on line 0, then a latency probe on line 1.
        frame_start();
        put_px(0, 0, 8'd100, 8'd100, 8'd100, 100);
        put_px(0, 1, 8'd255, 8'd0,   8'd0,   76);
        put_px(0, 2, 8'd0,   8'd255, 8'd0,   149);
        put_px(0, 3, 8'd0,   8'd0,   8'd255, 28);
        put_px(0, 4, 8'd0,   8'd0,   8'd0,   0);
        put_px(0, 5, 8'd255, 8'd255, 8'd255, 255);
        end_line();

        @(negedge clk);
        href  = 1'b1;
        clken = 1'b1;
        data  = {8'd7, 8'd7, 8'd7};
        push_exp(1, 0, 7);
        @(posedge clk); #1;
        check("lat_edge_t", post_clken, 0);
        @(negedge clk);
        clken = 1'b0;
        @(posedge clk); #1;
        check("lat_edge_t1", post_clken, 0);
        @(posedge clk); #1;
        check("lat_edge_t2", post_clken, 1);
        end_line();

        // Window and border frame, then a second frame with different data.
        send_frame(0);
        send_frame(100);

        // Reset in the middle of line 2.
        frame_start();
        send_line(0, W, 60);
        end_line();
        send_line(1, W, 60);
        end_line();
        send_line(2, 2, 60);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        href  = 1'b0;
        clken = 1'b0;
        #1;
        check("async_rst_matrix", post_matrix, 0);
        check("async_rst_gray", post_gray, 0);
        check("async_rst_sync", {post_vsync, post_href, post_clken}, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(50);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rgb_gray_matrix3x3.md
Name: rgb_gray_matrix3x3

Overview:
- First processing stage of the Canny edge pipeline; consumes the camera-style pixel stream (VSYNC/HREF/CLKEN/24-bit data) from the CMOS source.
- Converts RGB888 to 8-bit luma and buffers two lines.
- Emits, per input pixel, the gray value plus a 3x3 gray window for the downstream Gaussian/Sobel stages.
- Sync signals are delayed to stay aligned with the data.

Parameters:
- IMG_HDISP, 640, active pixels per line; line-buffer depth.
- IMG_VDISP, 480, active lines per frame; informational only, no logic depends on it.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset (see Behaviour)
- per_frame_vsync  in  1  frame valid; low during vertical sync, high otherwise
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel strobe; meaningful only while href=1
- per_img_data  in  24  pixel data; [23:16]=B, [15:8]=G, [7:0]=R
- post_frame_vsync  out  1  vsync delayed 3 clk
- post_frame_href  out  1  href delayed 3 clk
- post_frame_clken  out  1  clken delayed 3 clk
- post_img_gray  out  8  gray of current pixel (equals p33)
- post_matrix  out  72  window {p11,p12,p13,p21,p22,p23,p31,p32,p33}, p11 at [71:64], p33 at [7:0]

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk.
  - All outputs, pipeline registers and counters go to 0.
  - Line-buffer RAM is not cleared; stale contents are masked by the row counter.
- Pixel acceptance: a pixel is accepted on a clk edge where per_frame_href=1 and per_frame_clken=1. Ignore data at all other times.
- S1 (accept edge): register prod_r=R*77, prod_g=G*150, prod_b=B*29 (16 bits each), the valid flag, and column x / row y.
- S2: gray = (prod_r+prod_g+prod_b)>>8. The 16-bit sum cannot overflow (max 65280). gray is always ≤255.
- S3, on S2 valid:
  - Read lb1[x] (row y-1) and lb2[x] (row y-2).
  - Write lb2[x] <= lb1[x]; write lb1[x] <= gray (read-before-write in the same cycle).
  - Shift the window left: p11<=p12, p12<=p13, p13<=lb2[x]; same for row 2 with lb1[x]; row 3 with gray.
  - Result: p_r1 = column x-2, p_r3 = column x; p1c = row y-2, p3c = row y.
- Output timing:
  - Window registers hold between valid pixels.
  - post_* sync outputs are a 3-stage shift of the inputs, so an accepted pixel at edge t gives post_frame_clken=1 at edge t+3, window already updated.
- Column counter x (11 bit):
  - Reset to 0 on the href falling edge and on the vsync rising edge.
  - Increments per accepted pixel.
  - If x ≥ IMG_HDISP, no line-buffer write occurs; buffer taps read as 0. x saturates at 2047.
- Row counter y (2 bit, saturating at 2):
  - Reset to 0 on the vsync rising edge (frame start).
  - Increments on each href falling edge that had ≥1 accepted pixel.
- Zero masking, aligned to S3:
  - If y=0: row-1 and row-2 taps forced 0.
  - If y=1: row-1 taps forced 0.
  - When the column counter is 0 at line start, the window row registers are cleared before the shift, so p_r1=p_r2=0 at x=0 and p_r1=0 at x=1.
- Simultaneous vsync rise and href fall: the vsync reset wins.
- Mid-frame reset: output is masked as for a fresh frame until the next vsync rising edge plus two lines. No X values propagate.
- Lines shorter than IMG_HDISP: unwritten buffer entries keep old data, but next-row taps beyond the short line width still come from the buffer (unmasked).

Test Plan:
- Gray coefficients, R=G=B=100 -> post_img_gray=100.
  - Pure R=255 -> 76; pure G=255 -> 149; pure B=255 -> 28; all 0 -> 0; all 255 -> 255.
- Latency: single accepted pixel at edge t -> post_frame_clken high exactly at t+3.
  - post_frame_vsync/href equal the inputs delayed 3 clk throughout a frame.
- Window content:
  - Setup: 4x4 frame with R=G=B=10*y+x, clken every other cycle (IMG_HDISP=4).
  - At (y=2,x=2): post_matrix = {0,1,2,10,11,12,20,21,22}.
  - At (y=3,x=3): post_matrix = {11,12,13,21,22,23,31,32,33}.
- Borders, same frame:
  - (y=0,x=3) -> {0,0,0,0,0,0,1,2,3}.
  - (y=1,x=0) -> {0,0,0,0,0,0,0,0,10}.
  - (y=2,x=1) -> {0,0,1,0,10,11,0,20,21}.
- Second frame after the vsync gap, with different data -> row 0 windows show zeros in rows 1-2, not previous-frame data.
- rst_n pulsed low mid-line 2:
  - All outputs are 0 immediately (asynchronous).
  - After release and the next vsync rise, the first two lines are masked exactly as in the border test.
